// File: rtl/vpu_wb_packer_pkg.sv
// ---------------------------------------------------------------------------
// vpu_wb_packer_pkg : shared widths and FSM encoding for the VPU write-back packer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vpu_wb_packer_pkg;

   localparam int DATA_W     = 16;
   localparam int LANES      = 4;
   localparam int UB_WORD_W  = DATA_W * LANES;
   localparam int ADDR_W     = 10;
   localparam int FIFO_DEPTH = 8;

   typedef enum logic [1:0] {
      WB_IDLE = 2'd0,
      WB_RUN  = 2'd1,
      WB_DONE = 2'd2
   } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/vpu_wb_packer_if.sv
// ---------------------------------------------------------------------------
// vpu_wb_packer_if : Unified Buffer write port (val/rdy, address, packed word)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface vpu_wb_packer_if #(
   parameter int ADDR_W = vpu_wb_packer_pkg::ADDR_W,
   parameter int WORD_W = vpu_wb_packer_pkg::UB_WORD_W
);
   logic              ub_wr_val;
   logic              ub_wr_rdy;
   logic [ADDR_W-1:0] ub_wr_addr;
   logic [WORD_W-1:0] ub_wr_data;

   modport master (
      output ub_wr_val,
      output ub_wr_addr,
      output ub_wr_data,
      input  ub_wr_rdy
   );

   modport slave (
      input  ub_wr_val,
      input  ub_wr_addr,
      input  ub_wr_data,
      output ub_wr_rdy
   );
endinterface

`default_nettype wire

// File: rtl/vpu_wb_packer_sync_fifo.sv
// ---------------------------------------------------------------------------
// vpu_wb_packer_sync_fifo : single-clock FIFO, push accepted on full when popping
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vpu_wb_packer_sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             flush_i,
   input  wire logic             push_i,
   input  wire logic             pop_i,
   input  wire logic [WIDTH-1:0] din_i,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [WIDTH-1:0]      head_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   cnt_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
            2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/vpu_wb_packer.sv
// ---------------------------------------------------------------------------
// vpu_wb_packer : deskews four VPU lanes and writes packed 64b rows to the UB
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vpu_wb_packer #(
   parameter int DATA_W     = vpu_wb_packer_pkg::DATA_W,
   parameter int ADDR_W     = vpu_wb_packer_pkg::ADDR_W,
   parameter int LANES      = vpu_wb_packer_pkg::LANES,
   parameter int FIFO_DEPTH = vpu_wb_packer_pkg::FIFO_DEPTH
) (
   input  wire logic                    clk,
   input  wire logic                    rst,
   input  wire logic                    start,
   input  wire logic [ADDR_W-1:0]       base_addr,
   input  wire logic [ADDR_W-1:0]       row_count,
   input  wire logic [LANES*DATA_W-1:0] lane_data,
   input  wire logic [LANES-1:0]        lane_valid,
   vpu_wb_packer_if.master              ub,
   output logic                         busy,
   output logic                         done,
   output logic                         overflow
);

   import vpu_wb_packer_pkg::*;

   wb_state_t                state_q;
   logic [ADDR_W-1:0]        base_q;
   logic [ADDR_W-1:0]        count_q;
   logic [ADDR_W-1:0]        wr_cnt_q;
   logic                     overflow_q;

   logic [LANES-1:0]         fifo_empty;
   logic [LANES-1:0]         fifo_full;
   logic [LANES*DATA_W-1:0]  fifo_heads;
   logic [LANES-1:0]         push;
   logic [LANES-1:0]         drop;
   logic                     run;
   logic                     flush;
   logic                     wr_val;
   logic                     wr_fire;

   assign run     = (state_q == WB_RUN);
   assign flush   = (state_q == WB_DONE);
   assign wr_val  = run & ~|fifo_empty;
   assign wr_fire = wr_val & ub.ub_wr_rdy;
   assign push    = lane_valid & {LANES{run}};
   // A full lane only loses data when the row isn't being drained this cycle.
   assign drop    = push & fifo_full & {LANES{~wr_fire}};

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         vpu_wb_packer_sync_fifo #(
            .WIDTH (DATA_W),
            .DEPTH (FIFO_DEPTH)
         ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .flush_i (flush),
            .push_i  (push[gi]),
            .pop_i   (wr_fire),
            .din_i   (lane_data[gi*DATA_W +: DATA_W]),
            .full_o  (fifo_full[gi]),
            .empty_o (fifo_empty[gi]),
            .head_o  (fifo_heads[gi*DATA_W +: DATA_W])
         );
      end
   endgenerate

   assign ub.ub_wr_val  = wr_val;
   assign ub.ub_wr_addr = wr_val ? (base_q + wr_cnt_q) : '0;
   assign ub.ub_wr_data = wr_val ? fifo_heads : '0;
   assign busy          = (state_q != WB_IDLE);
   assign done          = (state_q == WB_DONE);
   assign overflow      = overflow_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= WB_IDLE;
         base_q     <= '0;
         count_q    <= '0;
         wr_cnt_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (|drop) overflow_q <= 1'b1;
         case (state_q)
            WB_IDLE: begin
               if (start) begin
                  base_q   <= base_addr;
                  count_q  <= row_count;
                  wr_cnt_q <= '0;
                  state_q  <= (row_count == '0) ? WB_DONE : WB_RUN;
               end
            end
            WB_RUN: begin
               if (wr_fire) begin
                  wr_cnt_q <= wr_cnt_q + ADDR_W'(1);
                  if (wr_cnt_q == count_q - ADDR_W'(1)) state_q <= WB_DONE;
               end
            end
            WB_DONE: state_q <= WB_IDLE;
            default: state_q <= WB_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_vpu_wb_packer.sv
// ---------------------------------------------------------------------------
// tb_vpu_wb_packer : directed stimulus with a queue scoreboard on the UB port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vpu_wb_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  base_addr = '0;
   logic [9:0]  row_count = '0;
   logic [63:0] lane_data = '0;
   logic [3:0]  lane_valid = '0;
   logic        busy, done, overflow;

   vpu_wb_packer_if #(.ADDR_W(10), .WORD_W(64)) ub_if ();

   vpu_wb_packer dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .row_count  (row_count),
      .lane_data  (lane_data),
      .lane_valid (lane_valid),
      .ub         (ub_if),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [73:0] exp_q [$];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_word(input logic [9:0] a, input logic [63:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic drive_row(input logic [3:0] v, input logic [63:0] d);
      lane_valid = v;
      lane_data  = d;
      tick();
      lane_valid = '0;
   endtask

   task automatic start_job(input logic [9:0] b, input logic [9:0] c);
      start     = 1'b1;
      base_addr = b;
      row_count = c;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int budget);
      int k = 0;
      while (!done && k < budget) begin
         tick();
         k++;
      end
      check(nm, 64'(done), 64'd1);
   endtask

   task automatic check_drained(input string nm);
      check(nm, 64'(exp_q.size()), 64'd0);
   endtask

   // Monitor: every accepted UB write must match the oldest expected word
   always @(negedge clk) begin
      logic [73:0] e;
      if (!rst && ub_if.ub_wr_val && ub_if.ub_wr_rdy) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %h data %h, required no write",
                     ub_if.ub_wr_addr, ub_if.ub_wr_data);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 64'(ub_if.ub_wr_addr), 64'(e[73:64]));
            check("wr_data", ub_if.ub_wr_data, e[63:0]);
         end
      end
   end

   initial begin
      logic [63:0] w;
      ub_if.ub_wr_rdy = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      // Reset state
      check("rst_val",  64'(ub_if.ub_wr_val), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_ovf",  64'(overflow), 64'd0);
      check("rst_addr", 64'(ub_if.ub_wr_addr), 64'd0);
      check("rst_data", ub_if.ub_wr_data, 64'd0);

      // 1: aligned rows
      start_job(10'h010, 10'd2);
      check("t1_busy", 64'(busy), 64'd1);
      expect_word(10'h010, 64'h0004_0003_0002_0001);
      expect_word(10'h011, 64'h0008_0007_0006_0005);
      lane_valid = 4'hF; lane_data = 64'h0004_0003_0002_0001; tick();
      check("t1_latency_val", 64'(ub_if.ub_wr_val), 64'd1);
      lane_data = 64'h0008_0007_0006_0005; tick();
      lane_valid = '0;
      wait_done("t1_done", 10);
      tick();
      check("t1_done_pulse", 64'(done), 64'd0);
      check("t1_busy_fall", 64'(busy), 64'd0);
      check_drained("t1_drained");

      // 2: lane i staggered by i cycles
      start_job(10'h040, 10'd4);
      for (int r = 0; r < 4; r++) begin
         w = '0;
         for (int i = 0; i < 4; i++) w[i*16 +: 16] = 16'hA000 + 16'(r*16 + i);
         expect_word(10'h040 + 10'(r), w);
      end
      for (int c = 0; c < 7; c++) begin
         lane_valid = '0;
         lane_data  = '0;
         for (int i = 0; i < 4; i++) begin
            if (c >= i && c - i < 4) begin
               lane_valid[i] = 1'b1;
               lane_data[i*16 +: 16] = 16'hA000 + 16'((c - i)*16 + i);
            end
         end
         tick();
      end
      lane_valid = '0;
      wait_done("t2_done", 10);
      check("t2_no_ovf", 64'(overflow), 64'd0);
      tick();
      check_drained("t2_drained");

      // 3: backpressure after the first write
      start_job(10'h080, 10'd4);
      expect_word(10'h080, 64'h1003_1002_1001_1000);
      expect_word(10'h081, 64'h1013_1012_1011_1010);
      expect_word(10'h082, 64'h1023_1022_1021_1020);
      expect_word(10'h083, 64'h1033_1032_1031_1030);
      drive_row(4'hF, 64'h1003_1002_1001_1000);
      tick();
      ub_if.ub_wr_rdy = 1'b0;
      drive_row(4'hF, 64'h1013_1012_1011_1010);
      drive_row(4'hF, 64'h1023_1022_1021_1020);
      drive_row(4'hF, 64'h1033_1032_1031_1030);
      for (int k = 0; k < 5; k++) begin
         check("t3_hold_val",  64'(ub_if.ub_wr_val), 64'd1);
         check("t3_hold_addr", 64'(ub_if.ub_wr_addr), 64'h081);
         check("t3_hold_data", ub_if.ub_wr_data, 64'h1013_1012_1011_1010);
         tick();
      end
      ub_if.ub_wr_rdy = 1'b1;
      wait_done("t3_done", 10);
      tick();
      check_drained("t3_drained");

      // 4: lane 0 overfilled while stalled
      ub_if.ub_wr_rdy = 1'b0;
      start_job(10'h100, 10'd8);
      for (int r = 0; r < 9; r++) begin
         lane_valid = 4'b0001;
         lane_data  = 64'(16'h0100 + 16'(r));
         tick();
         if (r == 7) check("t4_no_ovf_at_8", 64'(overflow), 64'd0);
      end
      check("t4_ovf_set", 64'(overflow), 64'd1);
      for (int r = 0; r < 8; r++) begin
         w = '0;
         w[15:0] = 16'h0100 + 16'(r);
         for (int i = 1; i < 4; i++) w[i*16 +: 16] = 16'h0B00 + 16'(r*16 + i);
         expect_word(10'h100 + 10'(r), w);
         lane_valid = 4'b1110;
         lane_data  = w;
         tick();
      end
      lane_valid = '0;
      ub_if.ub_wr_rdy = 1'b1;
      wait_done("t4_done", 15);
      check("t4_ovf_sticky", 64'(overflow), 64'd1);
      tick();
      check_drained("t4_drained");
      rst = 1'b1; tick(); rst = 1'b0;
      check("t4_rst_clears_ovf", 64'(overflow), 64'd0);

      // 5a: zero-row job
      start_job(10'h155, 10'd0);
      check("t5_zero_done", 64'(done), 64'd1);
      check("t5_zero_val", 64'(ub_if.ub_wr_val), 64'd0);
      tick();
      check("t5_zero_idle", 64'(busy), 64'd0);

      // 5b: address wrap, with a start pulse during RUN that must be ignored
      start_job(10'h3FF, 10'd2);
      expect_word(10'h3FF, 64'h2222_2222_1111_1111);
      expect_word(10'h000, 64'h4444_4444_3333_3333);
      start = 1'b1; base_addr = 10'h200; row_count = 10'd5;
      drive_row(4'hF, 64'h2222_2222_1111_1111);
      start = 1'b0;
      drive_row(4'hF, 64'h4444_4444_3333_3333);
      wait_done("t5_wrap_done", 10);
      tick();
      check_drained("t5_drained");

      // 6: reset after one of three writes
      start_job(10'h020, 10'd3);
      expect_word(10'h020, 64'h5003_5002_5001_5000);
      drive_row(4'hF, 64'h5003_5002_5001_5000);
      tick();
      check_drained("t6_first_written");
      rst = 1'b1;
      tick();
      check("t6_rst_val",  64'(ub_if.ub_wr_val), 64'd0);
      check("t6_rst_busy", 64'(busy), 64'd0);
      check("t6_rst_done", 64'(done), 64'd0);
      check("t6_rst_addr", 64'(ub_if.ub_wr_addr), 64'd0);
      check("t6_rst_data", ub_if.ub_wr_data, 64'd0);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t6_no_done", 64'(done), 64'd0);
      end
      start_job(10'h030, 10'd1);
      expect_word(10'h030, 64'h6003_6002_6001_6000);
      drive_row(4'hF, 64'h6003_6002_6001_6000);
      wait_done("t6_new_done", 10);
      tick();
      check_drained("t6_drained");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
